// File: rtl/acl_spi_responder_if.sv
// SPI pin bundle between a polling master and the ADXL362-style responder.
interface acl_spi_responder_if;
  logic sclk;
  logic mosi;
  logic csn;
  logic miso;
  logic miso_oe;

  modport master (output sclk, output mosi, output csn, input miso, input miso_oe);
  modport slave  (input sclk, input mosi, input csn, output miso, output miso_oe);
endinterface

// File: rtl/acl_spi_responder.sv
// SPI mode-0 responder emulating an ADXL362-style accelerometer register file.
// SPI pins are oversampled on clk; nothing is clocked by sclk.
module acl_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DEVID_AD    = 8'hAD,
  parameter logic [7:0]  PARTID      = 8'hF2
) (
  input  logic                clk,
  input  logic                rst,
  acl_spi_responder_if.slave  spi,
  input  logic [11:0]         x_in,
  input  logic [11:0]         y_in,
  input  logic [11:0]         z_in,
  input  logic                sample_valid,
  output logic [7:0]          power_ctl,
  output logic                cmd_err,
  output logic                busy
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_RD, S_WR, S_SKIP} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, csn_sync;
  logic                   sclk_prev, csn_prev;
  logic                   sclk_s, mosi_s, csn_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

  state_t      state;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_sr;
  logic [7:0]  rx_byte;
  logic [5:0]  addr, load_addr;
  logic        is_read;
  logic [7:0]  tx_sr, rd_data;
  logic        byte_done, dr_clear;

  logic [11:0] shadow_x, shadow_y, shadow_z;
  logic [11:0] pend_x, pend_y, pend_z;
  logic [11:0] snap_x, snap_y, snap_z;
  logic        pend_v, data_ready;
  logic [7:0]  rw_regs [15];

  // csn synchronizer resets low so a reset inside a frame never sees a fresh
  // cs_fall; the remainder of that frame is ignored until csn rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      csn_sync  <= '0;
      sclk_prev <= 1'b0;
      csn_prev  <= 1'b0;
    end else begin
      sclk_sync[0] <= spi.sclk;
      mosi_sync[0] <= spi.mosi;
      csn_sync[0]  <= spi.csn;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync[i] <= sclk_sync[i-1];
        mosi_sync[i] <= mosi_sync[i-1];
        csn_sync[i]  <= csn_sync[i-1];
      end
      sclk_prev <= sclk_s;
      csn_prev  <= csn_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign csn_s     = csn_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_fall   = ~csn_s & csn_prev;
  assign cs_rise   = csn_s & ~csn_prev;

  assign rx_byte   = {rx_sr, mosi_s};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);
  assign dr_clear  = byte_done && !cs_rise && (state == S_RD) && (addr == 6'h0E);
  assign busy      = (state != S_IDLE);
  assign power_ctl = rw_regs[13];

  // Address of the byte about to be loaded for transmission.
  assign load_addr = (state == S_ADDR) ? rx_byte[5:0] : addr + 6'd1;

  always_comb begin
    rd_data = '0;
    case (load_addr)
      6'h00:   rd_data = DEVID_AD;
      6'h01:   rd_data = 8'h1D;
      6'h02:   rd_data = PARTID;
      6'h08:   rd_data = snap_x[11:4];
      6'h09:   rd_data = snap_y[11:4];
      6'h0A:   rd_data = snap_z[11:4];
      6'h0B:   rd_data = {7'd0, data_ready};
      6'h0E:   rd_data = snap_x[7:0];
      6'h0F:   rd_data = {{4{snap_x[11]}}, snap_x[11:8]};
      6'h10:   rd_data = snap_y[7:0];
      6'h11:   rd_data = {{4{snap_y[11]}}, snap_y[11:8]};
      6'h12:   rd_data = snap_z[7:0];
      6'h13:   rd_data = {{4{snap_z[11]}}, snap_z[11:8]};
      default: if (load_addr >= 6'h20 && load_addr <= 6'h2E) rd_data = rw_regs[load_addr[3:0]];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      rx_sr       <= '0;
      addr        <= '0;
      is_read     <= 1'b0;
      tx_sr       <= '0;
      cmd_err     <= 1'b0;
      spi.miso    <= 1'b0;
      spi.miso_oe <= 1'b0;
      snap_x      <= '0;
      snap_y      <= '0;
      snap_z      <= '0;
      for (int unsigned i = 0; i < 15; i++) rw_regs[i] <= '0;
    end else begin
      cmd_err <= 1'b0;
      if (cs_rise) begin
        state       <= S_IDLE;
        spi.miso    <= 1'b0;
        spi.miso_oe <= 1'b0;
      end else if (state == S_IDLE) begin
        if (cs_fall) begin
          state       <= S_CMD;
          bit_cnt     <= '0;
          spi.miso_oe <= 1'b1;
          snap_x      <= shadow_x;
          snap_y      <= shadow_y;
          snap_z      <= shadow_z;
        end
      end else begin
        if (sclk_rise && state != S_SKIP) begin
          rx_sr   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            case (state)
              S_CMD: begin
                if (rx_byte == 8'h0B) begin
                  is_read <= 1'b1;
                  state   <= S_ADDR;
                end else if (rx_byte == 8'h0A) begin
                  is_read <= 1'b0;
                  state   <= S_ADDR;
                end else begin
                  cmd_err  <= 1'b1;
                  spi.miso <= 1'b0;
                  state    <= S_SKIP;
                end
              end
              S_ADDR: begin
                addr <= rx_byte[5:0];
                if (is_read) begin
                  tx_sr <= rd_data;
                  state <= S_RD;
                end else begin
                  state <= S_WR;
                end
              end
              S_RD: begin
                addr  <= addr + 6'd1;
                tx_sr <= rd_data;
              end
              S_WR: begin
                addr <= addr + 6'd1;
                if (addr >= 6'h20 && addr <= 6'h2E) begin
                  rw_regs[addr[3:0]] <= rx_byte;
                end else if (addr == 6'h1F && rx_byte == 8'h52) begin
                  for (int unsigned i = 0; i < 15; i++) rw_regs[i] <= '0;
                end
              end
              default: ;
            endcase
          end
        end
        if (sclk_fall && state == S_RD) begin
          spi.miso <= tx_sr[7];
          tx_sr    <= {tx_sr[6:0], 1'b0};
        end
      end
    end
  end

  // Strobes during a frame are parked and applied at cs_rise so the snapshot
  // never changes under a burst; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_x   <= '0;
      shadow_y   <= '0;
      shadow_z   <= '0;
      pend_x     <= '0;
      pend_y     <= '0;
      pend_z     <= '0;
      pend_v     <= 1'b0;
      data_ready <= 1'b0;
    end else begin
      if (dr_clear) data_ready <= 1'b0;
      if (cs_rise && busy) begin
        pend_v <= 1'b0;
        if (sample_valid) begin
          shadow_x   <= x_in;
          shadow_y   <= y_in;
          shadow_z   <= z_in;
          data_ready <= 1'b1;
        end else if (pend_v) begin
          shadow_x   <= pend_x;
          shadow_y   <= pend_y;
          shadow_z   <= pend_z;
          data_ready <= 1'b1;
        end
      end else if (sample_valid) begin
        if (busy) begin
          pend_x <= x_in;
          pend_y <= y_in;
          pend_z <= z_in;
          pend_v <= 1'b1;
        end else begin
          shadow_x   <= x_in;
          shadow_y   <= y_in;
          shadow_z   <= z_in;
          data_ready <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_acl_spi_responder.sv
// Directed bench for acl_spi_responder: a table of register frames plus
// hand-written sequences for coherency, aborts, bad commands and async reset.
module tb_acl_spi_responder;

  localparam int HALF = 8;  // sclk half period in clk cycles

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] x_in = '0, y_in = '0, z_in = '0;
  logic        sample_valid = 1'b0;
  logic [7:0]  power_ctl;
  logic        cmd_err;
  logic        busy;

  acl_spi_responder_if spi ();

  acl_spi_responder #(.SYNC_STAGES(2), .DEVID_AD(8'hAD), .PARTID(8'hF2)) dut (
    .clk          (clk),
    .rst          (rst),
    .spi          (spi.slave),
    .x_in         (x_in),
    .y_in         (y_in),
    .z_in         (z_in),
    .sample_valid (sample_valid),
    .power_ctl    (power_ctl),
    .cmd_err      (cmd_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int err_pulses = 0;
  int miso_hi = 0;

  always @(negedge clk) begin
    if (cmd_err) err_pulses++;
    if (spi.miso) miso_hi++;
  end

  // d holds up to six bytes, first byte in the top octet.
  typedef struct {
    string       name;
    bit          smp;
    logic [11:0] sx, sy, sz;
    logic [7:0]  cmd, addr;
    int          n;
    logic [47:0] d;
    logic [7:0]  pc;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pulse_sample(input logic [11:0] sx, input logic [11:0] sy, input logic [11:0] sz);
    @(negedge clk);
    x_in = sx; y_in = sy; z_in = sz; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nb; i--) begin
      spi.mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = spi.miso;
      spi.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi.sclk = 1'b0;
    end
  endtask

  task automatic frame_open();
    spi.csn = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic frame_close(input string nm);
    repeat (HALF) @(negedge clk);
    chk({nm, "_oe"}, {7'd0, spi.miso_oe}, 8'd1);
    spi.csn = 1'b1;
    repeat (4) @(negedge clk);
    chk({nm, "_busy_end"}, {7'd0, busy}, 8'd0);
    chk({nm, "_miso_idle"}, {7'd0, spi.miso}, 8'd0);
    repeat (HALF) @(negedge clk);
  endtask

  task automatic run_frame(input string nm, input logic [7:0] cmd, input logic [7:0] addr,
                           input int n, input logic [47:0] d);
    logic [7:0] rx;
    frame_open();
    xfer_bits(cmd, 8, rx);
    xfer_bits(addr, 8, rx);
    for (int i = 0; i < n; i++) begin
      if (cmd == 8'h0A) begin
        xfer_bits(d[47-8*i -: 8], 8, rx);
      end else begin
        xfer_bits(8'h00, 8, rx);
        chk($sformatf("%s_b%0d", nm, i), rx, d[47-8*i -: 8]);
      end
    end
    frame_close(nm);
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] got [6];
    int e0, m0;

    spi.sclk = 1'b0; spi.mosi = 1'b0; spi.csn = 1'b1;

    vt[0]  = '{"devid",       1'b0, 12'h000, 12'h000, 12'h000, 8'h0B, 8'h00, 3, 48'hAD1DF2000000, 8'h00};
    vt[1]  = '{"status_pre",  1'b1, 12'hF9C, 12'h064, 12'h000, 8'h0B, 8'h0B, 1, 48'h010000000000, 8'h00};
    vt[2]  = '{"sample_rd",   1'b0, 12'h000, 12'h000, 12'h000, 8'h0B, 8'h0E, 6, 48'h9CFF64000000, 8'h00};
    vt[3]  = '{"status_post", 1'b0, 12'h000, 12'h000, 12'h000, 8'h0B, 8'h0B, 1, 48'h000000000000, 8'h00};
    vt[4]  = '{"wr_pc",       1'b0, 12'h000, 12'h000, 12'h000, 8'h0A, 8'h2D, 1, 48'h020000000000, 8'h02};
    vt[5]  = '{"wrap",        1'b0, 12'h000, 12'h000, 12'h000, 8'h0B, 8'h3F, 2, 48'h00AD00000000, 8'h02};
    vt[6]  = '{"wr_20",       1'b0, 12'h000, 12'h000, 12'h000, 8'h0A, 8'h20, 1, 48'h550000000000, 8'h02};
    vt[7]  = '{"rd_20",       1'b0, 12'h000, 12'h000, 12'h000, 8'h0B, 8'h20, 1, 48'h550000000000, 8'h02};
    vt[8]  = '{"rd_hi",       1'b0, 12'h000, 12'h000, 12'h000, 8'h0B, 8'h08, 4, 48'hF90600000000, 8'h02};
    vt[9]  = '{"sr_bad",      1'b0, 12'h000, 12'h000, 12'h000, 8'h0A, 8'h1F, 1, 48'h110000000000, 8'h02};
    vt[10] = '{"rd_2c",       1'b0, 12'h000, 12'h000, 12'h000, 8'h0B, 8'h2C, 2, 48'h000200000000, 8'h02};

    repeat (5) @(negedge clk);
    chk("rst_miso",      {7'd0, spi.miso},    8'd0);
    chk("rst_miso_oe",   {7'd0, spi.miso_oe}, 8'd0);
    chk("rst_power_ctl", power_ctl,           8'd0);
    chk("rst_cmd_err",   {7'd0, cmd_err},     8'd0);
    chk("rst_busy",      {7'd0, busy},        8'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Unknown command: one cmd_err pulse and a silent miso for the whole frame.
    e0 = err_pulses; m0 = miso_hi;
    frame_open();
    xfer_bits(8'h0C, 8, rx);
    xfer_bits(8'hFF, 8, rx);
    xfer_bits(8'hFF, 8, rx);
    frame_close("badcmd");
    chk("badcmd_pulses", 8'(err_pulses - e0), 8'd1);
    chk("badcmd_miso",   8'(miso_hi - m0),    8'd0);

    // Write to 0x20 cut off after 5 data bits must leave it untouched.
    frame_open();
    xfer_bits(8'h0A, 8, rx);
    xfer_bits(8'h20, 8, rx);
    xfer_bits(8'hAA, 5, rx);
    frame_close("partial");
    run_frame("partial_rd", 8'h0B, 8'h20, 1, 48'h000000000000);

    for (int k = 0; k < 11; k++) begin
      if (vt[k].smp) pulse_sample(vt[k].sx, vt[k].sy, vt[k].sz);
      run_frame(vt[k].name, vt[k].cmd, vt[k].addr, vt[k].n, vt[k].d);
      chk({vt[k].name, "_pc"}, power_ctl, vt[k].pc);
    end

    // Strobe mid-burst: the rest of the burst keeps the old snapshot.
    frame_open();
    xfer_bits(8'h0B, 8, rx);
    xfer_bits(8'h0E, 8, rx);
    xfer_bits(8'h00, 8, got[0]);
    xfer_bits(8'h00, 8, got[1]);
    pulse_sample(12'h123, 12'h064, 12'h000);
    for (int i = 2; i < 6; i++) xfer_bits(8'h00, 8, got[i]);
    frame_close("coh");
    chk("coh_b0", got[0], 8'h9C);
    chk("coh_b1", got[1], 8'hFF);
    chk("coh_b2", got[2], 8'h64);
    chk("coh_b3", got[3], 8'h00);
    chk("coh_b4", got[4], 8'h00);
    chk("coh_b5", got[5], 8'h00);
    run_frame("coh_next", 8'h0B, 8'h0B, 5, 48'h010000230100);

    // Soft reset key clears the r/w block.
    run_frame("softrst", 8'h0A, 8'h1F, 1, 48'h520000000000);
    chk("softrst_pc", power_ctl, 8'h00);
    run_frame("softrst_2d", 8'h0B, 8'h2D, 1, 48'h000000000000);
    run_frame("softrst_20", 8'h0B, 8'h20, 1, 48'h000000000000);
    run_frame("wr_pc_0f", 8'h0A, 8'h2D, 1, 48'h0F0000000000);
    chk("wr_pc_0f_pc", power_ctl, 8'h0F);

    // Async reset in the middle of a DEVID read while miso is high.
    frame_open();
    xfer_bits(8'h0B, 8, rx);
    xfer_bits(8'h00, 8, rx);
    repeat (HALF) @(negedge clk);
    chk("pre_rst_miso", {7'd0, spi.miso}, 8'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_miso",      {7'd0, spi.miso},    8'd0);
    chk("arst_power_ctl", power_ctl,           8'd0);
    chk("arst_busy",      {7'd0, busy},        8'd0);
    chk("arst_miso_oe",   {7'd0, spi.miso_oe}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    xfer_bits(8'h00, 8, rx);
    xfer_bits(8'h0A, 8, rx);
    chk("arst_ignored_busy", {7'd0, busy}, 8'd0);
    spi.csn = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    run_frame("post_rst_devid", 8'h0B, 8'h00, 3, 48'hAD1DF2000000);
    run_frame("post_rst_samp",  8'h0B, 8'h0B, 5, 48'h0000000000_00);
    chk("post_rst_pc", power_ctl, 8'h00);
    chk("total_cmd_err", 8'(err_pulses), 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
